// File: rtl/sample3_pkg.sv
// Shared definitions for the three-sample collector: state encoding and default sample width.
package sample3_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HAVE1 = 2'd1,
    HAVE2 = 2'd2,
    FULL  = 2'd3
  } state_e;

  localparam int unsigned SAMPLE_W_DEF = 16;

endpackage

// File: rtl/sample3_collect.sv
// Gathers accepted samples into signed triplets (oldest, middle, newest) for a max-of-three stage.
// Build option SAMPLE3_SLIDE_EN turns non-overlapping triplets into a sliding window of three.
//
// state | meaning
// EMPTY | no sample held
// HAVE1 | out_a loaded
// HAVE2 | out_a, out_b loaded
// FULL  | triplet valid, waiting for out_ready
module sample3_collect
  import sample3_pkg::*;
#(
  parameter int W = SAMPLE_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  out_count
);

  state_e       state_q;
  logic [W-1:0] a_q, b_q, c_q;
  logic         valid_q;
  logic [15:0]  count_q;
  logic         accept;

  // A held triplet blocks input unless it leaves this cycle; flush only gates a partial triplet.
  assign in_ready = (state_q == FULL) ? out_ready : !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (!flush && accept) begin
            a_q     <= in_data;
            state_q <= HAVE1;
          end
        end
        HAVE1: begin
          if (flush) begin
            state_q <= EMPTY;
          end else if (accept) begin
            b_q     <= in_data;
            state_q <= HAVE2;
          end
        end
        HAVE2: begin
          if (flush) begin
            state_q <= EMPTY;
          end else if (accept) begin
            c_q     <= in_data;
            state_q <= FULL;
            valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (out_ready) begin
            count_q <= count_q + 16'd1;
`ifdef SAMPLE3_SLIDE_EN
            a_q <= b_q;
            b_q <= c_q;
            if (accept) begin
              c_q <= in_data;
            end else begin
              state_q <= HAVE2;
              valid_q <= 1'b0;
            end
`else
            valid_q <= 1'b0;
            if (accept) begin
              a_q     <= in_data;
              state_q <= HAVE1;
            end else begin
              state_q <= EMPTY;
            end
`endif
          end
        end
        default: begin
          state_q <= EMPTY;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_c     = c_q;
  assign out_valid = valid_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_sample3_collect.sv
// Directed bench for sample3_collect; the SAMPLE3_SLIDE_EN build runs the sliding-window sequence.
module tb_sample3_collect;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] out_a, out_b, out_c;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_count;

  int n_vec = 0;
  int n_err = 0;

  sample3_collect #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] s16(input int v);
    return {16'h0000, 16'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    in_valid = 1'b1;
    in_data  = 16'(v);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_trip(input string tag, input int a, input int b, input int c);
    check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_val({tag, "_a"}, 32'(out_a), s16(a));
    check_val({tag, "_b"}, 32'(out_b), s16(b));
    check_val({tag, "_c"}, 32'(out_c), s16(c));
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(out_count), 32'd0);
    check_val("rst_a", 32'(out_a), 32'd0);
    check_val("rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("post_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

`ifdef SAMPLE3_SLIDE_EN
    push(1); push(2); push(3);
    chk_trip("sl123", 1, 2, 3);
    push(4);
    chk_trip("sl234", 2, 3, 4);
    check_val("sl_cnt1", 32'(out_count), 32'd1);
    push(5);
    chk_trip("sl345", 3, 4, 5);
    check_val("sl_cnt2", 32'(out_count), 32'd2);
    tick();
    check_val("sl_cnt3", 32'(out_count), 32'd3);
    check_val("sl_have2_valid", 32'(out_valid), 32'd0);
    check_val("sl_have2_a", 32'(out_a), s16(4));
    check_val("sl_have2_b", 32'(out_b), s16(5));
    push(6);
    chk_trip("sl456", 4, 5, 6);
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk_trip("sl_flush_full", 4, 5, 6);
    // Each further push consumes one window: 65532 more bring the count to 0xFFFF.
    for (int i = 0; i < 65532; i++) push(i);
    check_val("sl_cnt_ffff", 32'(out_count), 32'h0000_FFFF);
    tick();
    check_val("sl_cnt_wrap", 32'(out_count), 32'd0);
`else
    // Basic triplet, latency 1 after the third sample.
    out_ready = 1'b1;
    push(5); push(-3);
    check_val("t1_pre_valid", 32'(out_valid), 32'd0);
    push(7);
    chk_trip("t1", 5, -3, 7);
    check_val("t1_cnt0", 32'(out_count), 32'd0);
    tick();
    check_val("t1_cnt1", 32'(out_count), 32'd1);
    check_val("t1_empty", 32'(out_valid), 32'd0);

    // Backpressure with extreme values.
    out_ready = 1'b0;
    push(-32768); push(32767); push(0);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'd99;
      #1;
      check_val("t2_ready_low", 32'(in_ready), 32'd0);
      tick();
      chk_trip("t2_hold", -32768, 32767, 0);
    end
    in_valid = 1'b1; in_data = 16'd9; out_ready = 1'b1;
    #1;
    check_val("t2_ready_high", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("t2_nobubble_valid", 32'(out_valid), 32'd0);
    check_val("t2_nobubble_a", 32'(out_a), s16(9));
    check_val("t2_cnt", 32'(out_count), 32'd2);
    push(10); push(11);
    chk_trip("t2_next", 9, 10, 11);
    tick();
    check_val("t2_cnt3", 32'(out_count), 32'd3);

    // Flush drops partial triplet and the sample offered with it.
    push(1); push(2);
    flush = 1'b1; in_valid = 1'b1; in_data = 16'd3;
    #1;
    check_val("t3_flush_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    push(4); push(5);
    check_val("t3_not_full", 32'(out_valid), 32'd0);
    push(6);
    chk_trip("t3", 4, 5, 6);
    flush = 1'b1; out_ready = 1'b0;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    chk_trip("t3_flush_full", 4, 5, 6);
    tick();
    check_val("t3_cnt", 32'(out_count), 32'd4);

    // Asynchronous reset mid-triplet.
    push(7); push(8);
    #2 reset = 1'b1;
    #1;
    check_val("t4_valid", 32'(out_valid), 32'd0);
    check_val("t4_cnt", 32'(out_count), 32'd0);
    check_val("t4_a", 32'(out_a), 32'd0);
    check_val("t4_b", 32'(out_b), 32'd0);
    check_val("t4_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    push(20); push(21); push(22);
    chk_trip("t4_fresh", 20, 21, 22);
    tick();
    check_val("t4_cnt1", 32'(out_count), 32'd1);

    // Back-to-back streaming: 300 triplets, three cycles each.
    for (int i = 0; i < 900; i++) push(i + 100);
    chk_trip("t5_last", 997, 998, 999);
    check_val("t5_cnt_pre", 32'(out_count), 32'd300);
    tick();
    check_val("t5_cnt", 32'(out_count), 32'd301);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sample3_collect.md
SAMPLE3_COLLECT -- requirements
Module: sample3_collect

Interface
REQ-001 SHALL have parameter: W, 16, sample width in bits (signed two's complement).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  W  signed input sample.
REQ-005 SHALL have port: in_valid  input  1  in_data valid this cycle.
REQ-006 SHALL have port: in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port: flush  input  1  synchronous discard of a partial triplet.
REQ-008 SHALL have ports: out_a, out_b, out_c  output  W each  signed triplet (oldest, middle, newest), driving the downstream max-of-three stage.
REQ-009 SHALL have port: out_valid  output  1  triplet on out_a/b/c valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes triplet this cycle.
REQ-011 SHALL have port: out_count  output  16  number of triplets delivered, modulo 2^16.

Function
REQ-012 SHALL accept a sample when in_valid && in_ready at a clock edge; SHALL consume a triplet when out_valid && out_ready.
REQ-013 SHALL implement FSM states EMPTY, HAVE1, HAVE2, FULL; accepted sample: EMPTY->HAVE1, HAVE1->HAVE2, HAVE2->FULL.
REQ-014 SHALL store the first, second and third accepted samples into out_a, out_b, out_c respectively.
REQ-015 SHALL drive out_valid=1 exactly in FULL; triplet appears the cycle after the third sample is accepted (latency 1).
REQ-016 SHALL drive in_ready = (state != FULL) || out_ready (combinational on out_ready).
REQ-017 In FULL with out_ready=1 and a sample accepted in the same cycle: triplet is consumed and the new sample is loaded into out_a, next state HAVE1 (no bubble).
REQ-018 In FULL with out_ready=1 and no sample accepted: next state EMPTY.
REQ-019 In FULL with out_ready=0: out_a/b/c and state SHALL hold unchanged; no sample accepted.
REQ-020 SHALL increment out_count by 1 on each consumed triplet, wrapping 0xFFFF->0x0000.
REQ-021 flush=1 in EMPTY/HAVE1/HAVE2: next state EMPTY and any sample offered that cycle is dropped (in_ready SHALL be 0 while flush=1 outside FULL).
REQ-022 flush=1 in FULL: ignored; a completed triplet is never discarded.
REQ-023 SHALL not modify sample values; signed data passes bit-exact; out_a/b/c contents outside FULL are don't-care to the consumer.

Reset
REQ-024 On reset assertion, asynchronously: state EMPTY, out_a=out_b=out_c=0, out_valid=0, out_count=0.
REQ-025 in_ready SHALL be 1 during and immediately after reset; reset mid-triplet SHALL discard partial data.

Configuration
REQ-026 SHALL honour macro SAMPLE3_SLIDE_EN.
REQ-027 Without SAMPLE3_SLIDE_EN: non-overlapping triplets per REQ-013..REQ-019.
REQ-028 With SAMPLE3_SLIDE_EN: once FULL, each accepted sample consumed with the triplet shifts window (out_a<=out_b, out_b<=out_c, out_c<=sample), state remains FULL; consumption without a new sample -> state HAVE2 with out_a<=out_b, out_b<=out_c; flush in FULL remains ignored.

Structure
REQ-029 SHALL place FSM state encoding (2-bit typedef) and default width constant in shared package sample3_pkg.
REQ-030 SHALL be a single module with no sub-modules; downstream max-of-three instantiated by the parent, not inside this block.

Verification
REQ-031 Feed 5, -3, 7 with out_ready=1 -> next cycle out_a=5, out_b=-3, out_c=7, out_valid=1, out_count 0->1.
REQ-032 Feed -32768, 32767, 0 with out_ready=0 for 4 cycles -> in_ready=0, outputs held; raise out_ready with new sample 9 -> consumed, state HAVE1, out_a=9.
REQ-033 Feed 1, 2, then flush=1 with in_valid=1, in_data=3 -> state EMPTY, 3 dropped; then 4,5,6 -> triplet (4,5,6).
REQ-034 Assert reset in HAVE2 -> immediately out_valid=0, out_count=0, all outputs 0; next triplet starts fresh.
REQ-035 Preload out_count=0xFFFF via 65535 triplets; one more -> out_count=0x0000.
REQ-036 With SAMPLE3_SLIDE_EN, stream 1,2,3,4,5 with out_ready=1 -> triplets (1,2,3),(2,3,4),(3,4,5), out_count=3.
